// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin, burst-locked arbiter for the VGA adapter pixel-write port
// Optional: define VGA_PLOT_CLIP_EN to suppress plotting of beats with x>=160 or y>=120.
module vga_plot_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 256,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [X_W-1:0]         x_out,
    output logic [Y_W-1:0]         y_out,
    output logic [C_W-1:0]         colour_out,
    output logic                   plot_out,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    localparam int BC_W = 11;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nx;
    logic [2:0]      grant_r, last_grant;
    logic [BC_W-1:0] beat_cnt;

    // Requester signals padded to 8 entries so a 3-bit grant index always selects cleanly.
    logic [7:0]      valid_pad, last_pad, ready_pad;
    logic [X_W-1:0]  x_arr [8];
    logic [Y_W-1:0]  y_arr [8];
    logic [C_W-1:0]  c_arr [8];

    logic [3:0]      base, cand;
    logic            found;
    logic [2:0]      pick;

    logic            g_valid, g_last, accept, at_max, in_range;

    always_comb begin
        valid_pad = 8'(req_valid);
        last_pad  = 8'(req_last);
        for (int i = 0; i < 8; i++) begin
            x_arr[i] = '0;
            y_arr[i] = '0;
            c_arr[i] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            x_arr[i] = req_x[i*X_W +: X_W];
            y_arr[i] = req_y[i*Y_W +: Y_W];
            c_arr[i] = req_colour[i*C_W +: C_W];
        end
    end

    // Scan starts just after the last winner so it gets lowest priority next time.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        base  = {1'b0, last_grant} + 4'd1;
        if (base >= 4'(NUM_REQ))
            base = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = base + 4'(k);
            if (cand >= 4'(NUM_REQ))
                cand = cand - 4'(NUM_REQ);
            if (!found && valid_pad[cand[2:0]]) begin
                found = 1'b1;
                pick  = cand[2:0];
            end
        end
    end

    always_comb begin
        g_valid = valid_pad[grant_r];
        g_last  = last_pad[grant_r];
        accept  = (state == GRANT) && g_valid;
        at_max  = (beat_cnt == BC_W'(MAX_BURST - 1));
`ifdef VGA_PLOT_CLIP_EN
        in_range = (int'(x_arr[grant_r]) < 160) && (int'(y_arr[grant_r]) < 120);
`else
        in_range = 1'b1;
`endif
    end

    // A stalled requester releases the grant just like a finished sprite.
    always_comb begin
        state_nx  = state;
        ready_pad = '0;
        case (state)
            IDLE: begin
                if (found)
                    state_nx = GRANT;
            end
            GRANT: begin
                ready_pad[grant_r] = 1'b1;
                if (!g_valid || g_last || at_max)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign req_ready = ready_pad[NUM_REQ-1:0];
    assign busy      = (state == GRANT);
    assign grant_id  = grant_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_r    <= '0;
            last_grant <= 3'(NUM_REQ - 1);
            beat_cnt   <= '0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot_out   <= 1'b0;
        end else begin
            state    <= state_nx;
            plot_out <= accept && in_range;
            if (state == IDLE && found) begin
                grant_r    <= pick;
                last_grant <= pick;
                beat_cnt   <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (in_range) begin
                    x_out      <= x_arr[grant_r];
                    y_out      <= y_arr[grant_r];
                    colour_out <= c_arr[grant_r];
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - directed self-checking bench for vga_plot_arbiter
module tb_vga_plot_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid, req_last, req_ready;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  colour_out;
    logic        plot_out, busy;
    logic [2:0]  grant_id;

    int n_pass  = 0;
    int n_total = 0;

    // Requester model: pixel n has x = x0+n; last on every len-th pixel; valid while sent < stop.
    int   rq_sent [3];
    int   rq_stop [3];
    int   rq_len  [3];
    int   rq_x0   [3];
    logic acc     [3];
    logic tab_mode;
    logic [7:0] tab_x [4];
    logic [6:0] tab_y [4];

    vga_plot_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_last(req_last),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .req_ready(req_ready),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot_out(plot_out), .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_inputs;
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = (rq_sent[i] < rq_stop[i]);
            req_last[i]  = (((rq_sent[i] + 1) % rq_len[i]) == 0);
            if (tab_mode && i == 0) begin
                req_x[7:0] = tab_x[rq_sent[0] % 4];
                req_y[6:0] = tab_y[rq_sent[0] % 4];
            end else begin
                req_x[i*8 +: 8] = 8'(rq_x0[i] + rq_sent[i]);
                req_y[i*7 +: 7] = 7'(10 * i + 5);
            end
            req_colour[i*3 +: 3] = 3'(4 + i);
        end
    endtask

    task automatic clear_reqs;
        for (int i = 0; i < 3; i++) begin
            rq_sent[i] = 0;
            rq_stop[i] = 0;
            rq_len[i]  = 1;
            rq_x0[i]   = 0;
            acc[i]     = 1'b0;
        end
        tab_mode = 1'b0;
        drive_inputs();
    endtask

    // Advance one cycle; returns at the falling edge so outputs are sampled mid-cycle.
    task automatic tick;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            if (acc[i]) rq_sent[i]++;
        drive_inputs();
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            acc[i] = req_valid[i] && req_ready[i];
    endtask

    task automatic apply_reset;
        clear_reqs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_reqs();
        for (int i = 0; i < 3; i++) begin
            rq_stop[i] = 1000;
            rq_len[i]  = 1;
        end
        reset = 1'b1;
        tick();
        tick();
        tick();
        n_total++;
        if ({x_out, y_out, colour_out, plot_out, busy, grant_id, req_ready} !== 24'd0)
            $display("FAIL reset_state got x=%0d y=%0d c=%0d plot=%b busy=%b gid=%0d rdy=%b exp all zero",
                     x_out, y_out, colour_out, plot_out, busy, grant_id, req_ready);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_single_burst;
        logic exp_plot, exp_busy;
        apply_reset();
        rq_stop[0] = 4;
        rq_len[0]  = 4;
        rq_x0[0]   = 10;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp_plot = (t >= 3 && t <= 6);
            exp_busy = (t >= 2 && t <= 5);
            n_total++;
            if ({plot_out, busy} !== {exp_plot, exp_busy})
                $display("FAIL burst_plot_busy t=%0d got plot=%b busy=%b exp plot=%b busy=%b",
                         t, plot_out, busy, exp_plot, exp_busy);
            else n_pass++;
            if (t >= 3) begin
                n_total++;
                if ({x_out, y_out, colour_out} !== {8'(10 + (t >= 6 ? 3 : t - 3)), 7'd5, 3'b100})
                    $display("FAIL burst_data t=%0d got x=%0d y=%0d c=%b exp x=%0d y=5 c=100",
                             t, x_out, y_out, colour_out, 10 + (t >= 6 ? 3 : t - 3));
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin;
        int g, n;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            rq_stop[i] = 1000;
            rq_len[i]  = 1;
            rq_x0[i]   = 20 * (i + 1);
        end
        for (int t = 1; t <= 13; t++) begin
            tick();
            if (t >= 2 && t % 2 == 0) begin
                g = (t / 2 - 1) % 3;
                n_total++;
                if ({busy, grant_id, req_ready, plot_out} !== {1'b1, 3'(g), 3'(1 << g), 1'b0})
                    $display("FAIL rr_grant t=%0d got busy=%b gid=%0d rdy=%b plot=%b exp busy=1 gid=%0d rdy=%b plot=0",
                             t, busy, grant_id, req_ready, plot_out, g, 3'(1 << g));
                else n_pass++;
            end else if (t >= 3) begin
                g = ((t - 3) / 2) % 3;
                n = (t - 3) / 6;
                n_total++;
                if ({plot_out, x_out} !== {1'b1, 8'(20 * (g + 1) + n)})
                    $display("FAIL rr_plot t=%0d got plot=%b x=%0d exp plot=1 x=%0d",
                             t, plot_out, x_out, 20 * (g + 1) + n);
                else n_pass++;
            end
        end
    endtask

    task automatic test_max_burst;
        int plots;
        apply_reset();
        rq_stop[1] = 100000;
        rq_len[1]  = 100000;
        rq_x0[1]   = 0;
        rq_stop[2] = 1000;
        rq_len[2]  = 1;
        rq_x0[2]   = 77;
        plots = 0;
        for (int t = 1; t <= 259; t++) begin
            tick();
            if (plot_out) plots++;
            if (t == 2) begin
                n_total++;
                if ({busy, grant_id} !== {1'b1, 3'd1})
                    $display("FAIL max_first_grant got busy=%b gid=%0d exp busy=1 gid=1", busy, grant_id);
                else n_pass++;
            end
            if (t == 258) begin
                n_total++;
                if ({busy, plot_out, x_out} !== {1'b0, 1'b1, 8'd255})
                    $display("FAIL max_release got busy=%b plot=%b x=%0d exp busy=0 plot=1 x=255",
                             busy, plot_out, x_out);
                else n_pass++;
            end
            if (t == 259) begin
                n_total++;
                if ({busy, grant_id, plot_out} !== {1'b1, 3'd2, 1'b0})
                    $display("FAIL max_next_grant got busy=%b gid=%0d plot=%b exp busy=1 gid=2 plot=0",
                             busy, grant_id, plot_out);
                else n_pass++;
            end
        end
        n_total++;
        if (plots !== 256)
            $display("FAIL max_plot_count got %0d exp 256", plots);
        else n_pass++;
    endtask

    task automatic test_drop_valid;
        int plots;
        apply_reset();
        rq_stop[0] = 2;
        rq_len[0]  = 5;
        rq_x0[0]   = 30;
        rq_stop[1] = 1;
        rq_len[1]  = 1;
        rq_x0[1]   = 90;
        plots = 0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t <= 6 && plot_out) plots++;
            if (t == 4) begin
                n_total++;
                if ({plot_out, x_out} !== {1'b1, 8'd31})
                    $display("FAIL drop_second_plot got plot=%b x=%0d exp plot=1 x=31", plot_out, x_out);
                else n_pass++;
            end
            if (t == 5) begin
                n_total++;
                if ({busy, plot_out} !== 2'b00)
                    $display("FAIL drop_release got busy=%b plot=%b exp busy=0 plot=0", busy, plot_out);
                else n_pass++;
            end
            if (t == 6) begin
                n_total++;
                if ({busy, grant_id, req_ready} !== {1'b1, 3'd1, 3'b010})
                    $display("FAIL drop_next_grant got busy=%b gid=%0d rdy=%b exp busy=1 gid=1 rdy=010",
                             busy, grant_id, req_ready);
                else n_pass++;
            end
            if (t == 7) begin
                n_total++;
                if ({plot_out, x_out} !== {1'b1, 8'd90})
                    $display("FAIL drop_req1_plot got plot=%b x=%0d exp plot=1 x=90", plot_out, x_out);
                else n_pass++;
            end
        end
        n_total++;
        if (plots !== 2)
            $display("FAIL drop_plot_count got %0d exp 2", plots);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst;
        apply_reset();
        rq_stop[0] = 10;
        rq_len[0]  = 10;
        rq_x0[0]   = 50;
        for (int i = 1; i < 3; i++) begin
            rq_stop[i] = 1000;
            rq_len[i]  = 1;
        end
        for (int t = 1; t <= 4; t++) tick();
        n_total++;
        if ({plot_out, busy} !== 2'b11)
            $display("FAIL midrst_pre got plot=%b busy=%b exp plot=1 busy=1", plot_out, busy);
        else n_pass++;
        reset = 1'b1;
        tick();
        n_total++;
        if ({plot_out, busy, req_ready} !== 5'd0)
            $display("FAIL midrst_abandon got plot=%b busy=%b rdy=%b exp plot=0 busy=0 rdy=000",
                     plot_out, busy, req_ready);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) acc[i] = 1'b0;
        tick();
        n_total++;
        if ({busy, grant_id, req_ready} !== {1'b1, 3'd0, 3'b001})
            $display("FAIL midrst_priority got busy=%b gid=%0d rdy=%b exp busy=1 gid=0 rdy=001",
                     busy, grant_id, req_ready);
        else n_pass++;
    endtask

    task automatic test_clip;
        logic       ep;
        logic [7:0] ex;
        logic [6:0] ey;
        apply_reset();
        tab_mode = 1'b1;
        tab_x = '{8'd159, 8'd160, 8'd0, 8'd0};
        tab_y = '{7'd119, 7'd0, 7'd120, 7'd0};
        rq_stop[0] = 3;
        rq_len[0]  = 3;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t >= 2 && t <= 4) begin
                n_total++;
                if (req_ready[0] !== 1'b1)
                    $display("FAIL clip_ready t=%0d got %b exp 1", t, req_ready[0]);
                else n_pass++;
            end
            if (t >= 3 && t <= 5) begin
`ifdef VGA_PLOT_CLIP_EN
                ep = (t == 3);
                ex = 8'd159;
                ey = 7'd119;
`else
                ep = 1'b1;
                ex = tab_x[t - 3];
                ey = tab_y[t - 3];
`endif
                n_total++;
                if ({plot_out, x_out, y_out} !== {ep, ex, ey})
                    $display("FAIL clip_plot t=%0d got plot=%b x=%0d y=%0d exp plot=%b x=%0d y=%0d",
                             t, plot_out, x_out, y_out, ep, ex, ey);
                else n_pass++;
            end
            if (t == 6) begin
                n_total++;
                if ({plot_out, busy} !== 2'b00)
                    $display("FAIL clip_end got plot=%b busy=%b exp 0 0", plot_out, busy);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_drop_valid();
        test_reset_mid_burst();
        test_clip();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
